// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready payload slot with optional
// two-entry skid buffer, synchronous flush and saturating stall profiling.
module pipe_stage_reg #(
    parameter int WIDTH       = 32,
    parameter int SKID        = 1,
    parameter int BUBBLE_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic             in_CLK,
    input  logic             in_RST,
    input  logic             in_FLUSH,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_up_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             in_dn_ready,
    output logic [1:0]       out_count,
    output logic [CNT_W-1:0] out_stall_cnt
);

    logic             up_xfer;
    logic             dn_xfer;
    logic [WIDTH-1:0] main_q;
    logic [CNT_W-1:0] stall_q;

    assign up_xfer = in_valid & out_up_ready;
    assign dn_xfer = out_valid & in_dn_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                TWO   = 2'd2
            } state_t;

            state_t           state_q;
            logic [WIDTH-1:0] skid_q;

            always_ff @(posedge in_CLK) begin
                if (in_RST || in_FLUSH) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    unique case (state_q)
                        EMPTY: begin
                            if (up_xfer) begin
                                state_q <= ONE;
                                main_q  <= in_data;
                            end
                        end
                        ONE: begin
                            if (up_xfer && dn_xfer) begin
                                main_q <= in_data;
                            end else if (up_xfer) begin
                                state_q <= TWO;
                                skid_q  <= in_data;
                            end else if (dn_xfer) begin
                                state_q <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (dn_xfer) begin
                                state_q <= ONE;
                                main_q  <= skid_q;
                            end
                        end
                        default: state_q <= EMPTY;
                    endcase
                end
            end

            // Ready depends on state only, breaking the backpressure path.
            assign out_valid    = (state_q != EMPTY);
            assign out_up_ready = ~in_RST & (state_q != TWO);
            assign out_count    = state_q;
        end else begin : g_reg
            logic valid_q;

            always_ff @(posedge in_CLK) begin
                if (in_RST || in_FLUSH) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else if (up_xfer) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (dn_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid    = valid_q;
            assign out_up_ready = ~in_RST & (~valid_q | in_dn_ready);
            assign out_count    = {1'b0, valid_q};
        end
    endgenerate

    assign out_data = (BUBBLE_ZERO != 0 && !out_valid) ? '0 : main_q;

    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            stall_q <= '0;
        end else if (out_valid && !in_dn_ready && !in_FLUSH && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign out_stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, single-register and hold-data variants
// share stimulus and are tracked by a FIFO-level model each.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst, flush, vld, dn;
    logic [7:0] din;

    logic       rdy [3];
    logic       ov  [3];
    logic [7:0] od  [3];
    logic [1:0] oc  [3];
    logic [3:0]  sc0;
    logic [7:0]  sc1;
    logic [15:0] sc2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .SKID(1), .BUBBLE_ZERO(1), .CNT_W(4)) u0 (
        .in_CLK(clk), .in_RST(rst), .in_FLUSH(flush),
        .in_valid(vld), .in_data(din), .out_up_ready(rdy[0]),
        .out_valid(ov[0]), .out_data(od[0]), .in_dn_ready(dn),
        .out_count(oc[0]), .out_stall_cnt(sc0));

    pipe_stage_reg #(.WIDTH(8), .SKID(0), .BUBBLE_ZERO(1), .CNT_W(8)) u1 (
        .in_CLK(clk), .in_RST(rst), .in_FLUSH(flush),
        .in_valid(vld), .in_data(din), .out_up_ready(rdy[1]),
        .out_valid(ov[1]), .out_data(od[1]), .in_dn_ready(dn),
        .out_count(oc[1]), .out_stall_cnt(sc1));

    pipe_stage_reg #(.WIDTH(8), .SKID(1), .BUBBLE_ZERO(0), .CNT_W(16)) u2 (
        .in_CLK(clk), .in_RST(rst), .in_FLUSH(flush),
        .in_valid(vld), .in_data(din), .out_up_ready(rdy[2]),
        .out_valid(ov[2]), .out_data(od[2]), .in_dn_ready(dn),
        .out_count(oc[2]), .out_stall_cnt(sc2));

    function automatic int cap(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 15 : (i == 1) ? 255 : 65535;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each stage is a FIFO of depth cap(i); head is what is shown.
    int         msz   [3] = '{0, 0, 0};
    logic [7:0] mq    [3][2];
    logic [7:0] mshow [3] = '{8'h0, 8'h0, 8'h0};
    int         mcnt  [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit         mr, up, dx;
            logic [7:0] ed;
            int         sc;
            sc = (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
            mr = !rst && ((cap(i) == 2) ? (msz[i] < 2) : (msz[i] == 0 || dn));
            ed = (msz[i] > 0) ? mq[i][0] : ((i == 2) ? mshow[i] : 8'h0);
            if (chk_en) begin
                chk($sformatf("u%0d.valid", i), 32'(ov[i]), 32'(msz[i] > 0));
                chk($sformatf("u%0d.data", i), 32'(od[i]), 32'(ed));
                chk($sformatf("u%0d.ready", i), 32'(rdy[i]), 32'(mr));
                chk($sformatf("u%0d.count", i), 32'(oc[i]), 32'(msz[i]));
                chk($sformatf("u%0d.stall", i), 32'(sc), 32'(mcnt[i]));
            end
            up = vld && mr;
            dx = (msz[i] > 0) && dn;
            if (rst) begin
                msz[i]   = 0;
                mcnt[i]  = 0;
                mshow[i] = 8'h0;
            end else begin
                if (msz[i] > 0 && !dn && !flush && mcnt[i] < cmax(i))
                    mcnt[i]++;
                if (flush) begin
                    msz[i]   = 0;
                    mshow[i] = 8'h0;
                end else begin
                    if (dx) begin
                        mq[i][0] = mq[i][1];
                        msz[i]--;
                    end
                    if (up) begin
                        mq[i][msz[i]] = din;
                        msz[i]++;
                    end
                    if (msz[i] > 0) mshow[i] = mq[i][0];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; vld = 1'b0; dn = 1'b0; din = 8'h0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst.ready0", 32'(rdy[0]), 32'h0);
        chk("rst.valid0", 32'(ov[0]), 32'h0);
        chk("rst.data0", 32'(od[0]), 32'h0);
        rst = 1'b0;

        // Streaming with downstream always ready
        dn = 1'b1; vld = 1'b1; din = 8'h11;
        tick();
        chk("t1.d11", 32'(od[0]), 32'h11);
        chk("t1.cnt", 32'(oc[0]), 32'h1);
        din = 8'h22;
        tick();
        chk("t1.d22", 32'(od[0]), 32'h22);
        din = 8'h33;
        tick();
        chk("t1.d33", 32'(od[0]), 32'h33);
        chk("t1.stall", 32'(sc0), 32'h0);
        vld = 1'b0;
        tick();
        chk("t1.bubble", 32'(od[0]), 32'h0);
        chk("t1.hold", 32'(od[2]), 32'h33);

        // Fill the skid buffer, then drain in order
        dn = 1'b0; vld = 1'b1; din = 8'h0A;
        tick();
        din = 8'h0B;
        tick();
        chk("t2.count", 32'(oc[0]), 32'h2);
        chk("t2.ready", 32'(rdy[0]), 32'h0);
        chk("t2.head", 32'(od[0]), 32'h0A);
        din = 8'h0C; dn = 1'b1;
        #1;
        chk("t2.rdy_reg", 32'(rdy[0]), 32'h0);
        tick();
        chk("t2.dB", 32'(od[0]), 32'h0B);
        tick();
        chk("t2.dC", 32'(od[0]), 32'h0C);
        vld = 1'b0;
        tick();
        chk("t2.empty", 32'(ov[0]), 32'h0);

        // Flush while full, with a word offered
        dn = 1'b0; vld = 1'b1; din = 8'h0A;
        tick();
        din = 8'h0B;
        tick();
        chk("t3.full", 32'(oc[0]), 32'h2);
        din = 8'h0D; flush = 1'b1;
        tick();
        flush = 1'b0; vld = 1'b0;
        chk("t3.valid", 32'(ov[0]), 32'h0);
        chk("t3.data", 32'(od[0]), 32'h0);
        chk("t3.count", 32'(oc[0]), 32'h0);
        dn = 1'b1;
        tick();
        chk("t3.noD", 32'(ov[0]), 32'h0);

        // Reset while full
        dn = 1'b0; vld = 1'b1; din = 8'h01;
        tick();
        din = 8'h02;
        tick();
        rst = 1'b1; vld = 1'b0;
        #1;
        chk("t5.rdy0", 32'(rdy[0]), 32'h0);
        chk("t5.rdy1", 32'(rdy[1]), 32'h0);
        tick();
        chk("t5.valid", 32'(ov[0]), 32'h0);
        chk("t5.data", 32'(od[0]), 32'h0);
        chk("t5.count", 32'(oc[0]), 32'h0);
        chk("t5.stall", 32'(sc0), 32'h0);
        chk("t5.rdy_rst", 32'(rdy[0]), 32'h0);
        rst = 1'b0;
        #1;
        chk("t5.rdy_after", 32'(rdy[0]), 32'h1);

        // Stall counter saturation
        vld = 1'b1; din = 8'h05; dn = 1'b0;
        tick();
        vld = 1'b0;
        repeat (20) tick();
        chk("t4.sat", 32'(sc0), 32'hF);
        chk("t4.cnt8", 32'(sc1), 32'd20);
        dn = 1'b1;
        tick();
        tick();

        // Random traffic
        for (int c = 0; c < 1000; c++) begin
            vld   = ($urandom_range(0, 3) != 0);
            dn    = ($urandom_range(0, 4) < 3);
            din   = 8'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; vld = 1'b0; dn = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
